branch_ctrl: RTL and testbench

- Control-side sequencer for all PC-altering instructions: beq, bne, ble, bgt, j, jal, jr.
- Main control hands over with a start pulse after decode. This block drives the datapath and generates the PC-write request signals PCWrite, PCWriteCond, EQorNE and GTorLT consumed by the PC-load selection logic.
- Returns control with a one-cycle done pulse.

---
 rtl/branch_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_branch_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Sequencer for PC-altering instructions (beq/bne/ble/bgt/j/jal/jr).
// Moore FSM. Every output is a register loaded from the decode of the next state.
module branch_ctrl #(
    parameter logic [5:0] OP_RTYPE = 6'h00,
    parameter logic [5:0] OP_J     = 6'h02,
    parameter logic [5:0] OP_JAL   = 6'h03,
    parameter logic [5:0] OP_BEQ   = 6'h04,
    parameter logic [5:0] OP_BNE   = 6'h05,
    parameter logic [5:0] OP_BLE   = 6'h06,
    parameter logic [5:0] OP_BGT   = 6'h07,
    parameter logic [5:0] FUNCT_JR = 6'h08
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       busy,
    output logic       done,
    output logic       bad_op,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       EQorNE,
    output logic       GTorLT,
    output logic [1:0] PCSource,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       ALUOutWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemToReg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_BR_ADDR = 3'd1,
        S_BR_CMP  = 3'd2,
        S_LINK    = 3'd3,
        S_JUMP    = 3'd4,
        S_JR      = 3'd5,
        S_ERR     = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       bad_op;
        logic       pc_write;
        logic       pc_write_cond;
        logic       eq_or_ne;
        logic       gt_or_lt;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       alu_out_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
    } ctrl_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [5:0] r_opcode;
    logic [5:0] r_funct;
    logic [5:0] w_opcode_next;
    logic [5:0] w_funct_next;
    logic       w_accept;
    logic       w_is_branch;
    logic       w_is_jr;
    ctrl_t      r_ctrl;
    ctrl_t      w_ctrl_next;

    assign w_accept = (r_state == S_IDLE) && start;

    // The instruction in effect for the next state: fresh on acceptance, held otherwise.
    assign w_opcode_next = w_accept ? opcode : r_opcode;
    assign w_funct_next  = w_accept ? funct  : r_funct;

    assign w_is_branch = (w_opcode_next == OP_BEQ) || (w_opcode_next == OP_BNE) ||
                         (w_opcode_next == OP_BLE) || (w_opcode_next == OP_BGT);
    assign w_is_jr     = (w_opcode_next == OP_RTYPE) && (w_funct_next == FUNCT_JR);

    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_is_branch)                   w_state_next = S_BR_ADDR;
                    else if (w_opcode_next == OP_J)    w_state_next = S_JUMP;
                    else if (w_opcode_next == OP_JAL)  w_state_next = S_LINK;
                    else if (w_is_jr)                  w_state_next = S_JR;
                    else                               w_state_next = S_ERR;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_BR_ADDR: w_state_next = S_BR_CMP;
            S_BR_CMP:  w_state_next = S_DONE;
            S_LINK:    w_state_next = S_JUMP;
            S_JUMP:    w_state_next = S_DONE;
            S_JR:      w_state_next = S_DONE;
            S_ERR:     w_state_next = S_DONE;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ctrl_next      = '0;
        w_ctrl_next.busy = (w_state_next != S_IDLE);
        case (w_state_next)
            S_BR_ADDR: begin
                // ALUOut <= PC + (imm << 2): the branch target
                w_ctrl_next.alu_src_a     = 1'b0;
                w_ctrl_next.alu_src_b     = 2'b11;
                w_ctrl_next.alu_op        = 3'b001;
                w_ctrl_next.alu_out_write = 1'b1;
            end
            S_BR_CMP: begin
                w_ctrl_next.alu_src_a     = 1'b1;
                w_ctrl_next.alu_src_b     = 2'b00;
                w_ctrl_next.alu_op        = 3'b010;
                w_ctrl_next.pc_source     = 2'b01;
                w_ctrl_next.pc_write_cond = 1'b1;
                w_ctrl_next.eq_or_ne      = (w_opcode_next == OP_BEQ);
                w_ctrl_next.gt_or_lt      = (w_opcode_next == OP_BGT);
            end
            S_LINK: begin
                // PC already holds PC+4, so the link value comes straight from PC
                w_ctrl_next.reg_write  = 1'b1;
                w_ctrl_next.reg_dst    = 2'b10;
                w_ctrl_next.mem_to_reg = 2'b11;
            end
            S_JUMP: begin
                w_ctrl_next.pc_write  = 1'b1;
                w_ctrl_next.pc_source = 2'b10;
            end
            S_JR: begin
                w_ctrl_next.alu_src_a = 1'b1;
                w_ctrl_next.alu_op    = 3'b000;
                w_ctrl_next.pc_source = 2'b00;
                w_ctrl_next.pc_write  = 1'b1;
            end
            S_ERR: begin
                w_ctrl_next.bad_op = 1'b1;
            end
            S_DONE: begin
                w_ctrl_next.done = 1'b1;
            end
            default: begin
                w_ctrl_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_opcode <= '0;
            r_funct  <= '0;
            r_ctrl   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_opcode <= w_opcode_next;
            r_funct  <= w_funct_next;
            r_ctrl   <= w_ctrl_next;
        end
    end

    assign busy        = r_ctrl.busy;
    assign done        = r_ctrl.done;
    assign bad_op      = r_ctrl.bad_op;
    assign PCWrite     = r_ctrl.pc_write;
    assign PCWriteCond = r_ctrl.pc_write_cond;
    assign EQorNE      = r_ctrl.eq_or_ne;
    assign GTorLT      = r_ctrl.gt_or_lt;
    assign PCSource    = r_ctrl.pc_source;
    assign ALUSrcA     = r_ctrl.alu_src_a;
    assign ALUSrcB     = r_ctrl.alu_src_b;
    assign ALUOp       = r_ctrl.alu_op;
    assign ALUOutWrite = r_ctrl.alu_out_write;
    assign RegWrite    = r_ctrl.reg_write;
    assign RegDst      = r_ctrl.reg_dst;
    assign MemToReg    = r_ctrl.mem_to_reg;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: a queue of expected per-cycle output vectors is filled
// whenever the model is idle and start is seen, then compared every cycle.
module tb_branch_ctrl;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLE   = 6'h06;
    localparam logic [5:0] OP_BGT   = 6'h07;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       bad_op;
        logic       pc_write;
        logic       pc_write_cond;
        logic       eq_or_ne;
        logic       gt_or_lt;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       alu_out_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
    } obs_t;

    typedef enum {P_BR_ADDR, P_BR_CMP, P_LINK, P_JUMP, P_JR, P_ERR, P_DONE} phase_e;

    logic       clk;
    logic       reset;
    logic       start;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       busy, done, bad_op, PCWrite, PCWriteCond, EQorNE, GTorLT;
    logic [1:0] PCSource, ALUSrcB, RegDst, MemToReg;
    logic       ALUSrcA, ALUOutWrite, RegWrite;
    logic [2:0] ALUOp;

    branch_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .funct(funct),
        .busy(busy), .done(done), .bad_op(bad_op), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .EQorNE(EQorNE), .GTorLT(GTorLT),
        .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ALUOutWrite(ALUOutWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemToReg(MemToReg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    obs_t q_exp[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    function automatic obs_t sample();
        obs_t o;
        o.busy = busy; o.done = done; o.bad_op = bad_op; o.pc_write = PCWrite;
        o.pc_write_cond = PCWriteCond; o.eq_or_ne = EQorNE; o.gt_or_lt = GTorLT;
        o.pc_source = PCSource; o.alu_src_a = ALUSrcA; o.alu_src_b = ALUSrcB;
        o.alu_op = ALUOp; o.alu_out_write = ALUOutWrite; o.reg_write = RegWrite;
        o.reg_dst = RegDst; o.mem_to_reg = MemToReg;
        return o;
    endfunction

    // Control word each instruction phase must present, straight from the behaviour table.
    function automatic obs_t phase_vec(input phase_e p, input bit eq, input bit gt);
        obs_t v = '0;
        v.busy = 1'b1;
        case (p)
            P_BR_ADDR: begin v.alu_src_b = 2'b11; v.alu_op = 3'b001; v.alu_out_write = 1'b1; end
            P_BR_CMP:  begin v.alu_src_a = 1'b1; v.alu_op = 3'b010; v.pc_source = 2'b01;
                             v.pc_write_cond = 1'b1; v.eq_or_ne = eq; v.gt_or_lt = gt; end
            P_LINK:    begin v.reg_write = 1'b1; v.reg_dst = 2'b10; v.mem_to_reg = 2'b11; end
            P_JUMP:    begin v.pc_write = 1'b1; v.pc_source = 2'b10; end
            P_JR:      begin v.alu_src_a = 1'b1; v.pc_write = 1'b1; end
            P_ERR:     v.bad_op = 1'b1;
            P_DONE:    v.done = 1'b1;
            default:   v = '0;
        endcase
        return v;
    endfunction

    task automatic push_seq(input logic [5:0] op, input logic [5:0] fn);
        string kind;
        if (op == OP_BEQ || op == OP_BNE || op == OP_BLE || op == OP_BGT) begin
            q_exp.push_back(phase_vec(P_BR_ADDR, 0, 0));
            q_exp.push_back(phase_vec(P_BR_CMP, op == OP_BEQ, op == OP_BGT));
            kind = "branch";
        end else if (op == OP_JAL) begin
            q_exp.push_back(phase_vec(P_LINK, 0, 0));
            q_exp.push_back(phase_vec(P_JUMP, 0, 0));
            kind = "jal";
        end else if (op == OP_J) begin
            q_exp.push_back(phase_vec(P_JUMP, 0, 0));
            kind = "j";
        end else if (op == OP_RTYPE && fn == FUNCT_JR) begin
            q_exp.push_back(phase_vec(P_JR, 0, 0));
            kind = "jr";
        end else begin
            q_exp.push_back(phase_vec(P_ERR, 0, 0));
            kind = "illegal";
        end
        q_exp.push_back(phase_vec(P_DONE, 0, 0));
        $display("txn cyc=%0d op=%02h funct=%02h kind=%s", cyc, op, fn, kind);
    endtask

    task automatic check(input string tag, input obs_t o, input obs_t e);
        n_checks++;
        assert (o === e) n_pass++;
        else $error("FAIL %s@%0d observed=%h expected=%h", tag, cyc, o, e);
    endtask

    task automatic check_bit(input string tag, input logic o, input logic e);
        n_checks++;
        assert (o === e) n_pass++;
        else $error("FAIL %s@%0d observed=%b expected=%b", tag, cyc, o, e);
    endtask

    // One clock: drive inputs just after the rising edge, compare at the falling edge.
    task automatic cycle(input bit s, input logic [5:0] op, input logic [5:0] fn, input string tag);
        obs_t e;
        @(posedge clk);
        #1;
        start = s; opcode = op; funct = fn;
        @(negedge clk);
        cyc++;
        e = (q_exp.size() != 0) ? q_exp.pop_front() : obs_t'('0);
        check(tag, sample(), e);
        check_bit({tag, "_excl"}, PCWrite & PCWriteCond, 1'b0);
        if (!e.busy && s) push_seq(op, fn);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t zero;
        bit        s;
        int        sel;
        logic [5:0] op, fn;
        zero   = '0;
        reset  = 1'b1;
        start  = 1'b0;
        opcode = '0;
        funct  = '0;
        #7;
        check("reset", sample(), zero);
        #5 reset = 1'b0;

        cycle(0, 6'h00, 6'h00, "idle");
        // beq, then a j pulse during BR_CMP that must be ignored, then j accepted at T+4
        cycle(1, OP_BEQ, 6'h00, "beq_T");
        cycle(0, 6'h00, 6'h00, "beq_addr");
        cycle(1, OP_J,   6'h00, "beq_cmp");
        cycle(0, 6'h00, 6'h00, "beq_done");
        cycle(1, OP_J,   6'h00, "j_T");
        cycle(0, 6'h00, 6'h00, "j_jump");
        cycle(0, 6'h00, 6'h00, "j_done");
        // bne/ble/bgt sweep; a bne pulse during BR_ADDR of beq must not alter capture
        cycle(1, OP_BNE, 6'h00, "bne_T");
        for (int i = 0; i < 3; i++) cycle(0, 6'h00, 6'h00, "bne");
        cycle(1, OP_BLE, 6'h00, "ble_T");
        for (int i = 0; i < 3; i++) cycle(0, 6'h00, 6'h00, "ble");
        cycle(1, OP_BGT, 6'h00, "bgt_T");
        for (int i = 0; i < 3; i++) cycle(0, 6'h00, 6'h00, "bgt");
        cycle(1, OP_BEQ, 6'h00, "beq2_T");
        cycle(1, OP_BNE, 6'h00, "beq2_addr");
        for (int i = 0; i < 3; i++) cycle(0, 6'h00, 6'h00, "beq2");
        // jal, jr, illegal funct
        cycle(1, OP_JAL, 6'h00, "jal_T");
        for (int i = 0; i < 4; i++) cycle(0, 6'h00, 6'h00, "jal");
        cycle(1, OP_RTYPE, FUNCT_JR, "jr_T");
        for (int i = 0; i < 3; i++) cycle(0, 6'h00, 6'h00, "jr");
        cycle(1, OP_RTYPE, 6'h20, "ill_T");
        for (int i = 0; i < 3; i++) cycle(0, 6'h00, 6'h00, "ill");

        // asynchronous reset in the middle of BR_ADDR
        cycle(1, OP_BEQ, 6'h00, "rst_T");
        cycle(0, 6'h00, 6'h00, "rst_addr");
        #2 reset = 1'b1;
        #1 check("reset_mid", sample(), zero);
        q_exp.delete();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cycle(0, 6'h00, 6'h00, "post_rst_idle");
        cycle(1, OP_JAL, 6'h00, "post_rst_T");
        for (int i = 0; i < 4; i++) cycle(0, 6'h00, 6'h00, "post_rst");

        // randomized instruction mix with random (often ignored) start pulses
        for (int i = 0; i < 600; i++) begin
            s   = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 9);
            op  = (sel < 8) ? 6'(sel) : 6'($urandom_range(0, 63));
            fn  = ($urandom_range(0, 1) == 0) ? FUNCT_JR : 6'($urandom_range(0, 63));
            cycle(s, op, fn, "rand");
        end
        for (int i = 0; i < 5; i++) cycle(0, 6'h00, 6'h00, "drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
